// File: rtl/cfs_algn_pkg.sv
// Shared width derivations, FSM state encoding and RX FIFO field layout for the
// aligner RX path and its downstream FIFO controller.
package cfs_algn_pkg;

  function automatic int algn_offset_width(input int data_width);
    return (data_width <= 8) ? 1 : $clog2(data_width / 8);
  endfunction

  function automatic int algn_size_width(input int data_width);
    return $clog2(data_width / 8) + 1;
  endfunction

  function automatic int algn_fifo_width(input int data_width);
    return data_width + algn_offset_width(data_width) + algn_size_width(data_width);
  endfunction

  // FIFO entry is {size, offset, data} with data in the LSBs.
  localparam int FIFO_DATA_LSB = 0;

  function automatic int fifo_data_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int fifo_offset_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int fifo_offset_msb(input int data_width);
    return data_width + algn_offset_width(data_width) - 1;
  endfunction

  function automatic int fifo_size_lsb(input int data_width);
    return data_width + algn_offset_width(data_width);
  endfunction

  function automatic int fifo_size_msb(input int data_width);
    return algn_fifo_width(data_width) - 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } cfs_rx_state_e;

endpackage

// File: rtl/cfs_rx_legal.sv
// Combinational transfer legality check, shared with register-side validation.
module cfs_rx_legal
  import cfs_algn_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  localparam int ALGN_OFFSET_WIDTH = algn_offset_width(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH = algn_size_width(ALGN_DATA_WIDTH)
) (
  input  logic [ALGN_OFFSET_WIDTH-1:0] offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   size,
  output logic                         legal
);

  localparam int EW = ALGN_SIZE_WIDTH + 1;
  localparam int B = ALGN_DATA_WIDTH / 8;

  logic [EW-1:0] b_ext;
  logic [EW-1:0] off_ext;
  logic [EW-1:0] size_ext;
  logic [EW-1:0] div_ext;
  logic [EW-1:0] end_ext;
  logic [EW-1:0] mod_ext;

  // One extra bit of headroom so offset+size and B+offset never wrap.
  assign b_ext    = EW'(B);
  assign off_ext  = EW'(offset);
  assign size_ext = EW'(size);
  assign div_ext  = (size_ext == '0) ? EW'(1) : size_ext;
  assign end_ext  = off_ext + size_ext;
  assign mod_ext  = (b_ext + off_ext) % div_ext;

  assign legal = (size_ext != '0) && (end_ext <= b_ext) && (mod_ext == '0);

endmodule

// File: rtl/cfs_rx_ctrl.sv
// RX transfer controller: captures a master transfer, checks it, pushes legal
// entries to the RX FIFO and answers the master with a one-cycle ready strobe.
module cfs_rx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  localparam int ALGN_OFFSET_WIDTH = algn_offset_width(ALGN_DATA_WIDTH),
  localparam int ALGN_SIZE_WIDTH = algn_size_width(ALGN_DATA_WIDTH),
  localparam int FIFO_WIDTH = algn_fifo_width(ALGN_DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
  output logic                         md_rx_ready,
  output logic                         md_rx_err,
  output logic                         push_valid,
  output logic [FIFO_WIDTH-1:0]        push_data,
  input  logic                         push_ready,
  output logic [7:0]                   cnt_drop,
  input  logic                         cnt_drop_clr,
  output logic                         irq_drop,
  output logic [1:0]                   fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_PUSH = 2'(PUSH);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  logic [1:0] state;
  logic       legal;
  logic       take;
  logic       drop_inc;

  cfs_rx_legal #(.ALGN_DATA_WIDTH(ALGN_DATA_WIDTH)) u_legal (
    .offset (md_rx_offset),
    .size   (md_rx_size),
    .legal  (legal)
  );

  // Handshakes: md_rx_valid is sampled only in IDLE and is not required to stay
  // high afterwards; md_rx_ready is a one-cycle completion strobe with md_rx_err
  // qualifying it. push_valid/push_data hold steady until push_ready is seen.
  assign take     = (state == ST_IDLE) && md_rx_valid;
  assign drop_inc = take && !legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      md_rx_ready <= 1'b0;
      md_rx_err   <= 1'b0;
      push_valid  <= 1'b0;
      push_data   <= '0;
      irq_drop    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_rx_valid) begin
            push_data <= {md_rx_size, md_rx_offset, md_rx_data};
            if (legal) begin
              state      <= ST_PUSH;
              push_valid <= 1'b1;
            end else begin
              state       <= ST_RESP;
              md_rx_ready <= 1'b1;
              md_rx_err   <= 1'b1;
              irq_drop    <= 1'b1;
            end
          end
        end
        ST_PUSH: begin
          if (push_ready) begin
            state       <= ST_RESP;
            push_valid  <= 1'b0;
            md_rx_ready <= 1'b1;
            md_rx_err   <= 1'b0;
          end
        end
        ST_RESP: begin
          state       <= ST_IDLE;
          md_rx_ready <= 1'b0;
          md_rx_err   <= 1'b0;
          irq_drop    <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          md_rx_ready <= 1'b0;
          md_rx_err   <= 1'b0;
          push_valid  <= 1'b0;
          irq_drop    <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_drop <= 8'd0;
    end else if (cnt_drop_clr) begin
      cnt_drop <= 8'd0;
    end else if (drop_inc && (cnt_drop != 8'hFF)) begin
      cnt_drop <= cnt_drop + 8'd1;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Directed bench for cfs_rx_ctrl with a transaction-level reference model that
// is compared against the DUT outputs on every cycle out of reset.
module tb_cfs_rx_ctrl;
  import cfs_algn_pkg::*;

  localparam int DW = 32;
  localparam int OW = algn_offset_width(DW);
  localparam int SW = algn_size_width(DW);
  localparam int FW = algn_fifo_width(DW);
  localparam int NB = DW / 8;

  logic          clk;
  logic          reset_n;
  logic          md_rx_valid;
  logic [DW-1:0] md_rx_data;
  logic [OW-1:0] md_rx_offset;
  logic [SW-1:0] md_rx_size;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [FW-1:0] push_data;
  logic          push_ready;
  logic [7:0]    cnt_drop;
  logic          cnt_drop_clr;
  logic          irq_drop;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 0;

  cfs_rx_ctrl #(.ALGN_DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .cnt_drop     (cnt_drop),
    .cnt_drop_clr (cnt_drop_clr),
    .irq_drop     (irq_drop),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // reference model: a transfer is either waiting for the FIFO or being answered
  function automatic bit model_legal(input int off, input int sz);
    if (sz == 0) return 1'b0;
    return (off + sz <= NB) && (((NB + off) % sz) == 0);
  endfunction

  bit            m_wait;
  bit            m_resp;
  bit            m_err;
  logic [FW-1:0] m_entry;
  int            m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wait  <= 1'b0;
      m_resp  <= 1'b0;
      m_err   <= 1'b0;
      m_entry <= '0;
      m_cnt   <= 0;
    end else begin
      if (m_resp) begin
        m_resp <= 1'b0;
        m_err  <= 1'b0;
      end else if (m_wait) begin
        if (push_ready) begin
          m_wait <= 1'b0;
          m_resp <= 1'b1;
          m_err  <= 1'b0;
        end
      end else if (md_rx_valid) begin
        m_entry <= {md_rx_size, md_rx_offset, md_rx_data};
        if (model_legal(int'(md_rx_offset), int'(md_rx_size))) begin
          m_wait <= 1'b1;
        end else begin
          m_resp <= 1'b1;
          m_err  <= 1'b1;
        end
      end
      if (cnt_drop_clr)
        m_cnt <= 0;
      else if (!m_resp && !m_wait && md_rx_valid &&
               !model_legal(int'(md_rx_offset), int'(md_rx_size)) && m_cnt < 255)
        m_cnt <= m_cnt + 1;
    end
  end

  // scoreboard: every cycle out of reset
  always @(negedge clk) begin
    if (check_en && reset_n) begin
      chk("sb_push_valid", 64'(push_valid), 64'(m_wait));
      chk("sb_push_data", 64'(push_data), 64'(m_entry));
      chk("sb_ready", 64'(md_rx_ready), 64'(m_resp));
      chk("sb_err", 64'(md_rx_err), 64'(m_resp & m_err));
      chk("sb_irq", 64'(irq_drop), 64'(m_resp & m_err));
      chk("sb_cnt", 64'(cnt_drop), 64'(m_cnt));
    end
  end

  // driver: present a transfer for one cycle, return on the following negedge
  task automatic send(input int off, input int sz, input logic [DW-1:0] dat);
    @(negedge clk);
    md_rx_valid  = 1'b1;
    md_rx_offset = OW'(off);
    md_rx_size   = SW'(sz);
    md_rx_data   = dat;
    @(negedge clk);
    md_rx_valid  = 1'b0;
    md_rx_data   = DW'($urandom);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_drop_clr = 1'b1;
    @(negedge clk);
    cnt_drop_clr = 1'b0;
  endtask

  int n_legal;
  bit got;

  initial begin
    reset_n      = 1'b0;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b1;
    cnt_drop_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(md_rx_ready), 64'd0);
    chk("rst_err", 64'(md_rx_err), 64'd0);
    chk("rst_push_valid", 64'(push_valid), 64'd0);
    chk("rst_push_data", 64'(push_data), 64'd0);
    chk("rst_cnt", 64'(cnt_drop), 64'd0);
    chk("rst_irq", 64'(irq_drop), 64'd0);
    chk("rst_state", 64'(fsm_state), 64'(IDLE));
    reset_n  = 1'b1;
    check_en = 1'b1;

    // legal single-byte transfer at offset 1
    send(1, 1, 32'h0000AB00);
    chk("t1_push_valid", 64'(push_valid), 64'd1);
    chk("t1_push_data", 64'(push_data), 64'h5_0000_AB00);
    chk("t1_ready_early", 64'(md_rx_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready", 64'(md_rx_ready), 64'd1);
    chk("t1_err", 64'(md_rx_err), 64'd0);
    chk("t1_push_done", 64'(push_valid), 64'd0);
    @(negedge clk);
    chk("t1_ready_gone", 64'(md_rx_ready), 64'd0);

    // misaligned size: (4+1) mod 2 != 0
    send(1, 2, 32'h1234_5678);
    chk("t2_ready", 64'(md_rx_ready), 64'd1);
    chk("t2_err", 64'(md_rx_err), 64'd1);
    chk("t2_irq", 64'(irq_drop), 64'd1);
    chk("t2_cnt", 64'(cnt_drop), 64'd1);
    chk("t2_no_push", 64'(push_valid), 64'd0);
    @(negedge clk);
    chk("t2_irq_pulse", 64'(irq_drop), 64'd0);

    pulse_clr();
    chk("clr_cnt", 64'(cnt_drop), 64'd0);

    // zero size, then overflow past the bus
    send(0, 0, 32'hFFFF_FFFF);
    chk("t3a_err", 64'(md_rx_err), 64'd1);
    send(3, 2, 32'hFFFF_FFFF);
    chk("t3b_err", 64'(md_rx_err), 64'd1);
    @(negedge clk);
    chk("t3_cnt", 64'(cnt_drop), 64'd2);

    // FIFO back-pressure for 10 cycles
    push_ready = 1'b0;
    send(0, 4, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", 64'(push_valid), 64'd1);
      chk("t4_hold_data", 64'(push_data), 64'h10_DEAD_BEEF);
      chk("t4_no_ready", 64'(md_rx_ready), 64'd0);
    end
    push_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready", 64'(md_rx_ready), 64'd1);
    @(negedge clk);
    chk("t4_ready_once", 64'(md_rx_ready), 64'd0);

    // counter saturation, then clear against a coincident increment
    pulse_clr();
    for (int i = 0; i < 260; i++) send(1, 2, DW'(i));
    @(negedge clk);
    chk("t5_sat", 64'(cnt_drop), 64'd255);
    md_rx_valid  = 1'b1;
    md_rx_offset = OW'(1);
    md_rx_size   = SW'(2);
    cnt_drop_clr = 1'b1;
    @(negedge clk);
    md_rx_valid  = 1'b0;
    cnt_drop_clr = 1'b0;
    chk("t5_clr_wins", 64'(cnt_drop), 64'd0);
    chk("t5_irq", 64'(irq_drop), 64'd1);

    // reset while waiting on the FIFO
    push_ready = 1'b0;
    send(2, 2, 32'hCAFE_0000);
    chk("t6_push_valid", 64'(push_valid), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_push_valid", 64'(push_valid), 64'd0);
    chk("t6_rst_ready", 64'(md_rx_ready), 64'd0);
    chk("t6_rst_data", 64'(push_data), 64'd0);
    @(negedge clk);
    chk("t6_rst_hold_ready", 64'(md_rx_ready), 64'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    push_ready = 1'b1;
    send(0, 4, 32'h0BAD_F00D);
    chk("t6_after_push", 64'(push_valid), 64'd1);
    @(negedge clk);
    chk("t6_after_ready", 64'(md_rx_ready), 64'd1);
    chk("t6_after_err", 64'(md_rx_err), 64'd0);

    // sweep every offset/size pair with random FIFO stalls
    n_legal = 0;
    for (int off = 0; off < NB; off++) begin
      for (int sz = 0; sz < 8; sz++) begin
        send(off, sz, DW'($urandom));
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
          if (md_rx_ready) begin
            got = 1'b1;
            if (!md_rx_err) n_legal++;
          end else begin
            push_ready = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
          end
        end
        chk("t7_resp_seen", 64'(got), 64'd1);
        push_ready = 1'b1;
      end
    end
    chk("t7_legal_count", 64'(n_legal), 64'd7);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfs_rx_ctrl.md
CFS_RX_CTRL -- requirements
Module: cfs_rx_ctrl

Interface
REQ-001 Parameter ALGN_DATA_WIDTH, default 32, SHALL set the data bus width in bits; legal values are 8, 16, 32, 64, 128.
REQ-002 Derived width ALGN_OFFSET_WIDTH SHALL be 1 if ALGN_DATA_WIDTH<=8, else clog2(ALGN_DATA_WIDTH/8).
REQ-003 Derived width ALGN_SIZE_WIDTH SHALL be clog2(ALGN_DATA_WIDTH/8)+1.
REQ-004 Derived width FIFO_WIDTH SHALL be ALGN_DATA_WIDTH+ALGN_OFFSET_WIDTH+ALGN_SIZE_WIDTH.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port md_rx_valid, input, 1 bit: the upstream master presents a transfer.
REQ-008 Port md_rx_data, input, ALGN_DATA_WIDTH bits: transfer data.
REQ-009 Port md_rx_offset, input, ALGN_OFFSET_WIDTH bits: byte offset of the first valid byte.
REQ-010 Port md_rx_size, input, ALGN_SIZE_WIDTH bits: number of valid bytes.
REQ-011 Port md_rx_ready, output, 1 bit: one-cycle transfer-completion strobe.
REQ-012 Port md_rx_err, output, 1 bit: error response, qualified by md_rx_ready.
REQ-013 Port push_valid, output, 1 bit: an entry is offered to the RX FIFO.
REQ-014 Port push_data, output, FIFO_WIDTH bits: packed entry {size, offset, data}, with data in the LSBs.
REQ-015 Port push_ready, input, 1 bit: the RX FIFO accepts the entry.
REQ-016 Port cnt_drop, output, 8 bits: saturating count of illegal transfers.
REQ-017 Port cnt_drop_clr, input, 1 bit: synchronous clear of cnt_drop.
REQ-018 Port irq_drop, output, 1 bit: one-cycle pulse for each illegal transfer.

Function
REQ-019 The FSM SHALL have three states:
- IDLE: md_rx_ready=0, push_valid=0.
- PUSH: push_valid=1.
- RESP: md_rx_ready=1 for exactly one cycle.
REQ-020 A transfer SHALL be legal iff all of the following hold, with B=ALGN_DATA_WIDTH/8:
- size!=0;
- offset+size<=B;
- (B+offset) mod size==0.
Legality arithmetic SHALL be evaluated at ALGN_SIZE_WIDTH+1 bits so it cannot overflow.
REQ-021 In IDLE, md_rx_valid=1 SHALL cause the following on the next edge:
- data, offset and size are captured;
- if legal, the next state is PUSH;
- if illegal, the next state is RESP with md_rx_err=1.
REQ-022 In PUSH, push_data SHALL hold the captured {size, offset, data} and SHALL remain stable until push_ready=1.
REQ-023 In PUSH, push_valid=1 with push_ready=1 SHALL move the FSM to RESP with md_rx_err=0; push_valid SHALL be 0 in RESP.
REQ-024 RESP SHALL always return to IDLE after one cycle.
- A new transfer presented while in RESP is sampled in IDLE on the following cycle.
REQ-025 Minimum latency from md_rx_valid sampled to md_rx_ready SHALL be:
- 2 cycles for a legal transfer with push_ready held high;
- 1 cycle for an illegal transfer.
REQ-026 While push_ready=0 (FIFO full), the FSM SHALL stay in PUSH indefinitely with no data loss and no response.
REQ-027 The block SHALL ignore md_rx_valid deassertion after capture (protocol violation) and complete the transfer using the captured values.
REQ-028 An illegal transfer SHALL pulse irq_drop for one cycle in RESP and increment cnt_drop; cnt_drop SHALL saturate at 255.
REQ-029 When cnt_drop_clr and an increment occur in the same cycle, the clear SHALL win and the result SHALL be 0.
REQ-030 No FIFO entry SHALL ever be produced for an illegal transfer.

Reset
REQ-031 Reset SHALL force the following immediately:
- FSM state IDLE;
- md_rx_ready=0, md_rx_err=0, push_valid=0, push_data=0, cnt_drop=0, irq_drop=0.
REQ-032 Reset asserted mid-PUSH or mid-RESP SHALL abandon the transfer: no push and no response.
- After release, the FSM resumes in IDLE and samples md_rx_valid on the first edge.

Structure
REQ-033 Package cfs_algn_pkg SHALL hold:
- the width derivation functions/constants;
- the FSM state enum (IDLE, PUSH, RESP);
- the FIFO field MSB/LSB constants shared with the downstream controller.
REQ-034 The legality check SHALL be a combinational sub-module cfs_rx_legal (inputs offset and size; output legal), reused by register-side validation.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 With ALGN_DATA_WIDTH=32 and push_ready=1, driving offset=1, size=1, data=0x0000AB00 SHALL give:
- push_valid at cycle 1 with push_data={1,1,0x0000AB00};
- md_rx_ready=1, md_rx_err=0 at cycle 2.
REQ-037 Driving offset=1, size=2 (since (4+1) mod 2!=0) SHALL give md_rx_ready=1 and md_rx_err=1 at cycle 1, irq_drop pulse, cnt_drop=1, and no push_valid.
REQ-038 Driving size=0, then separately offset=3 with size=2, SHALL give two error responses and cnt_drop=2.
REQ-039 A legal transfer with push_ready=0 for 10 cycles SHALL hold push_valid and push_data stable for 10 cycles.
- md_rx_ready SHALL pulse exactly 1 cycle after push_ready rises.
REQ-040 260 illegal transfers SHALL leave cnt_drop=255; then cnt_drop_clr coinciding with a 261st illegal transfer's increment SHALL leave cnt_drop=0.
REQ-041 reset_n asserted while in PUSH SHALL drop push_valid=0 asynchronously with no md_rx_ready.
- A new legal transfer after release SHALL complete normally in 2 cycles.
